functional_lane_resolver: RTL and testbench

Parametrised functional-lane resolver for MBINIT. It accumulates per-lane Data-to-Clock training pass/fail results over a configurable number of iterations and reduces them to a group-level functional-lane map. It sits between the MBINIT point-test result collection and the REPAIRMB/width-degrade logic. It generalises the fixed 16-lane, two-half setup to N lanes in G groups, with multi-iteration accumulation, an explicit fail indication and a start/done handshake.

---
 rtl/fls_pkg.sv | 21 ++
 rtl/fls_result_accumulator.sv | 47 ++++
 rtl/functional_lane_resolver.sv | 202 ++++++++++++++++++++
 tb/tb_functional_lane_resolver.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fls_pkg.sv
// Shared types and helpers for the functional-lane resolver.
// Holds the FSM state encoding and the lanes-per-group helper.
package fls_pkg;

    localparam logic [1:0] FLS_ENC_IDLE    = 2'b00;
    localparam logic [1:0] FLS_ENC_COLLECT = 2'b01;
    localparam logic [1:0] FLS_ENC_RESOLVE = 2'b10;
    localparam logic [1:0] FLS_ENC_DONE    = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = FLS_ENC_IDLE,
        COLLECT = FLS_ENC_COLLECT,
        RESOLVE = FLS_ENC_RESOLVE,
        DONE    = FLS_ENC_DONE
    } fls_state_e;

    function automatic int fls_lanes_per_group(input int num_lanes, input int num_groups);
        return num_lanes / num_groups;
    endfunction

endpackage

// File: rtl/fls_result_accumulator.sv
// Per-lane AND accumulator with iteration counter; done_strobe marks the
// cycle in which the final sample of a run is accepted.
module fls_result_accumulator
    import fls_pkg::*;
#(
    parameter int NUM_LANES  = 16,
    parameter int ITERATIONS = 4
) (
    input  logic                 CLK,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 valid,
    input  logic [NUM_LANES-1:0] lane_result,
    output logic [NUM_LANES-1:0] acc,
    output logic                 done_strobe
);

    localparam int CNT_W = $clog2(ITERATIONS + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ITERATIONS - 1);

    logic [NUM_LANES-1:0] acc_r;
    logic [CNT_W-1:0]     count_r;
    logic                 last_s;

    assign last_s = (count_r == LAST_IDX);

    // Accumulator and sample counter; clear has priority over a sample.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            acc_r   <= {NUM_LANES{1'b1}};
            count_r <= {CNT_W{1'b0}};
        end else if (clear) begin
            acc_r   <= {NUM_LANES{1'b1}};
            count_r <= {CNT_W{1'b0}};
        end else if (valid) begin
            acc_r   <= acc_r & lane_result;
            count_r <= last_s ? {CNT_W{1'b0}} : count_r + CNT_W'(1);
        end else begin
            acc_r   <= acc_r;
            count_r <= count_r;
        end
    end

    assign acc         = acc_r;
    assign done_strobe = valid & ~clear & last_s;

endmodule

// File: rtl/functional_lane_resolver.sv
// MBINIT functional-lane resolver: FSM, group reduction and priority select.
// Optional COLLECT watchdog enabled by defining FLS_TIMEOUT_EN.
module functional_lane_resolver
    import fls_pkg::*;
#(
    parameter int NUM_LANES      = 16,
    parameter int NUM_GROUPS     = 2,
    parameter int ITERATIONS     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                             CLK,
    input  logic                             rst_n,
    input  logic                             i_start,
    input  logic                             i_result_valid,
    input  logic [NUM_LANES-1:0]             i_lane_result,
    output logic [NUM_GROUPS-1:0]            o_lane_map,
    output logic [$clog2(NUM_LANES+1)-1:0]   o_lane_count,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_fail,
    output logic                             o_timeout
);

    localparam int LPG     = fls_lanes_per_group(NUM_LANES, NUM_GROUPS);
    localparam int COUNT_W = $clog2(NUM_LANES + 1);

    fls_state_e              state_r;
    fls_state_e              next_state_s;
    logic                    sample_valid_s;
    logic                    done_strobe_s;
    logic                    timeout_hit_s;
    logic [NUM_LANES-1:0]    acc_s;
    logic [NUM_GROUPS-1:0]   group_ok_s;
    logic [NUM_GROUPS-1:0]   map_s;
    logic                    fail_s;
    logic [COUNT_W-1:0]      count_s;

    logic [NUM_GROUPS-1:0]   lane_map_r;
    logic [COUNT_W-1:0]      lane_count_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    fail_r;

    // A start in the same cycle as a sample drops the sample.
    assign sample_valid_s = i_result_valid & (state_r == COLLECT) & ~i_start;

    fls_result_accumulator #(
        .NUM_LANES  (NUM_LANES),
        .ITERATIONS (ITERATIONS)
    ) u_acc (
        .CLK         (CLK),
        .rst_n       (rst_n),
        .clear       (i_start),
        .valid       (sample_valid_s),
        .lane_result (i_lane_result),
        .acc         (acc_s),
        .done_strobe (done_strobe_s)
    );

`ifdef FLS_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] timer_r;
    logic             timeout_r;

    // Watchdog: counts COLLECT cycles, restarted on every start.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            timer_r <= {TMR_W{1'b0}};
        end else if (i_start) begin
            timer_r <= {TMR_W{1'b0}};
        end else if (state_r == COLLECT) begin
            timer_r <= timer_r + TMR_W'(1);
        end else begin
            timer_r <= timer_r;
        end
    end

    assign timeout_hit_s = (state_r == COLLECT) & ~i_start & ~done_strobe_s
                         & (timer_r == TMR_W'(TIMEOUT_CYCLES - 1));

    // Timeout flag, cleared by a new run.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            timeout_r <= 1'b0;
        end else if (i_start) begin
            timeout_r <= 1'b0;
        end else if (timeout_hit_s) begin
            timeout_r <= 1'b1;
        end else begin
            timeout_r <= timeout_r;
        end
    end

    assign o_timeout = timeout_r;
`else
    logic unused_timeout_cfg_s;

    assign unused_timeout_cfg_s = ^TIMEOUT_CYCLES;
    assign timeout_hit_s        = 1'b0;
    assign o_timeout            = 1'b0;
`endif

    // State register.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; a start from any state (re)enters COLLECT.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_start) next_state_s = COLLECT;
                else         next_state_s = IDLE;
            end
            COLLECT: begin
                if (i_start)            next_state_s = COLLECT;
                else if (done_strobe_s) next_state_s = RESOLVE;
                else if (timeout_hit_s) next_state_s = DONE;
                else                    next_state_s = COLLECT;
            end
            RESOLVE: begin
                if (i_start) next_state_s = COLLECT;
                else         next_state_s = DONE;
            end
            DONE: begin
                if (i_start) next_state_s = COLLECT;
                else         next_state_s = DONE;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Group reduction: a group is functional only if every lane passed.
    always_comb begin
        group_ok_s = {NUM_GROUPS{1'b0}};
        for (int g = 0; g < NUM_GROUPS; g++) begin
            group_ok_s[g] = &acc_s[g*LPG +: LPG];
        end
    end

    // Priority select: all groups, else the highest ok group alone, else none.
    always_comb begin
        map_s   = {NUM_GROUPS{1'b0}};
        count_s = {COUNT_W{1'b0}};
        fail_s  = ~|group_ok_s;
        if (&group_ok_s) begin
            map_s = {NUM_GROUPS{1'b1}};
        end else begin
            for (int g = 0; g < NUM_GROUPS; g++) begin
                if (group_ok_s[g]) begin
                    map_s    = {NUM_GROUPS{1'b0}};
                    map_s[g] = 1'b1;
                end else begin
                    map_s = map_s;
                end
            end
        end
        for (int g = 0; g < NUM_GROUPS; g++) begin
            count_s = count_s + (map_s[g] ? COUNT_W'(LPG) : {COUNT_W{1'b0}});
        end
    end

    // Registered outputs.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            lane_map_r   <= {NUM_GROUPS{1'b1}};
            lane_count_r <= COUNT_W'(NUM_LANES);
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            fail_r       <= 1'b0;
        end else begin
            busy_r <= (next_state_s == COLLECT) | (next_state_s == RESOLVE);
            done_r <= (next_state_s == DONE);
            if (i_start) begin
                fail_r <= 1'b0;
            end else if (state_r == RESOLVE) begin
                lane_map_r   <= map_s;
                lane_count_r <= count_s;
                fail_r       <= fail_s;
            end else if (timeout_hit_s) begin
                lane_map_r   <= {NUM_GROUPS{1'b0}};
                lane_count_r <= {COUNT_W{1'b0}};
                fail_r       <= 1'b1;
            end else begin
                fail_r <= fail_r;
            end
        end
    end

    assign o_lane_map   = lane_map_r;
    assign o_lane_count = lane_count_r;
    assign o_busy       = busy_r;
    assign o_done       = done_r;
    assign o_fail       = fail_r;

endmodule

// File: tb/tb_functional_lane_resolver.sv
// Self-checking bench for functional_lane_resolver: directed scenarios plus
// randomized traffic against a run-level reference model.
module tb_functional_lane_resolver;

    localparam int NL    = 16;
    localparam int NG    = 2;
    localparam int IT    = 4;
    localparam int TO    = 16;
    localparam int LPG   = NL / NG;
    localparam int GMASK = (1 << LPG) - 1;
    localparam int CW    = $clog2(NL + 1);

    localparam int P_IDLE = 0;
    localparam int P_COLL = 1;
    localparam int P_RES  = 2;
    localparam int P_DONE = 3;

    logic          CLK = 1'b0;
    logic          rst_n;
    logic          i_start;
    logic          i_result_valid;
    logic [NL-1:0] i_lane_result;
    logic [NG-1:0] o_lane_map;
    logic [CW-1:0] o_lane_count;
    logic          o_busy;
    logic          o_done;
    logic          o_fail;
    logic          o_timeout;

    int n_vec = 0;
    int n_bad = 0;

    // reference model state
    int            m_phase;
    logic [NL-1:0] m_acc;
    int            m_n;
    int            m_tmr;
    logic [31:0]   e_map, e_cnt, e_busy, e_done, e_fail, e_to;

    always #5 CLK = ~CLK;

    functional_lane_resolver #(
        .NUM_LANES      (NL),
        .NUM_GROUPS     (NG),
        .ITERATIONS     (IT),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK            (CLK),
        .rst_n          (rst_n),
        .i_start        (i_start),
        .i_result_valid (i_result_valid),
        .i_lane_result  (i_lane_result),
        .o_lane_map     (o_lane_map),
        .o_lane_count   (o_lane_count),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_fail         (o_fail),
        .o_timeout      (o_timeout)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_acc   = '1;
        m_n     = 0;
        m_tmr   = 0;
        e_map   = (1 << NG) - 1;
        e_cnt   = NL;
        e_busy  = 0;
        e_done  = 0;
        e_fail  = 0;
        e_to    = 0;
    endtask

    task automatic model_resolve();
        int ok_cnt;
        int top;
        ok_cnt = 0;
        top    = -1;
        for (int g = 0; g < NG; g++) begin
            if (((int'(m_acc) >> (g * LPG)) & GMASK) == GMASK) begin
                ok_cnt++;
                top = g;
            end
        end
        if (ok_cnt == NG)   e_map = (1 << NG) - 1;
        else if (top >= 0)  e_map = 1 << top;
        else                e_map = 0;
        e_fail  = (ok_cnt == 0);
        e_cnt   = $countones(e_map) * LPG;
        e_done  = 1;
        e_busy  = 0;
        m_phase = P_DONE;
    endtask

    task automatic model_step(input logic s, input logic v, input logic [NL-1:0] d);
        if (s) begin
            m_phase = P_COLL;
            m_acc   = '1;
            m_n     = 0;
            m_tmr   = 0;
            e_busy  = 1;
            e_done  = 0;
            e_fail  = 0;
            e_to    = 0;
        end else if (m_phase == P_COLL) begin
            if (v) begin
                m_acc = m_acc & d;
                m_n++;
            end
            if (v && m_n == IT) m_phase = P_RES;
`ifdef FLS_TIMEOUT_EN
            else if (m_tmr == TO - 1) begin
                m_phase = P_DONE;
                e_map   = 0;
                e_cnt   = 0;
                e_fail  = 1;
                e_to    = 1;
                e_done  = 1;
                e_busy  = 0;
            end else m_tmr++;
`endif
        end else if (m_phase == P_RES) begin
            model_resolve();
        end
    endtask

    task automatic check_outputs();
        check_eq("lane_map",   32'(o_lane_map),   e_map);
        check_eq("lane_count", 32'(o_lane_count), e_cnt);
        check_eq("busy",       32'(o_busy),       e_busy);
        check_eq("done",       32'(o_done),       e_done);
        check_eq("fail",       32'(o_fail),       e_fail);
        check_eq("timeout",    32'(o_timeout),    e_to);
    endtask

    // one clock: drive at negedge, step model at posedge, check at next negedge
    task automatic tick(input logic s, input logic v, input logic [NL-1:0] d);
        i_start        = s;
        i_result_valid = v;
        i_lane_result  = d;
        @(posedge CLK);
        model_step(s, v, d);
        @(negedge CLK);
        check_outputs();
    endtask

    task automatic run4(input logic [NL-1:0] a, b, c, d);
        tick(1'b1, 1'b0, '0);
        tick(1'b0, 1'b1, a);
        tick(1'b0, 1'b1, b);
        tick(1'b0, 1'b1, c);
        tick(1'b0, 1'b1, d);
        tick(1'b0, 1'b0, '0);
        tick(1'b0, 1'b0, '0);
    endtask

    initial begin
        int lat;
        int r;
        logic s, v;
        logic [NL-1:0] d;

        rst_n          = 1'b0;
        i_start        = 1'b0;
        i_result_valid = 1'b0;
        i_lane_result  = '0;
        model_reset();
        repeat (2) @(negedge CLK);
        check_eq("rst_map",   32'(o_lane_map),   32'd3);
        check_eq("rst_count", 32'(o_lane_count), 32'd16);
        check_outputs();
        rst_n = 1'b1;

        // all-pass with latency measurement
        tick(1'b1, 1'b0, '0);
        lat = 1;
        for (int i = 0; i < IT; i++) begin
            tick(1'b0, 1'b1, 16'hFFFF);
            lat++;
        end
        while (!o_done && lat < 20) begin
            tick(1'b0, 1'b0, '0);
            lat++;
        end
        check_eq("all_pass_latency", 32'(lat), 32'd6);
        check_eq("all_pass_map",     32'(o_lane_map),   32'd3);
        check_eq("all_pass_count",   32'(o_lane_count), 32'd16);

        // intermittent lane in the lower group
        run4(16'hFFFF, 16'hFFFB, 16'hFFFF, 16'hFFFF);
        check_eq("intermit_map",   32'(o_lane_map),   32'd2);
        check_eq("intermit_count", 32'(o_lane_count), 32'd8);

        // both groups fail
        run4(16'h7FFF, 16'hFFFE, 16'hFFFF, 16'hFFFF);
        check_eq("bothfail_map",  32'(o_lane_map), 32'd0);
        check_eq("bothfail_fail", 32'(o_fail),     32'd1);
        check_eq("bothfail_done", 32'(o_done),     32'd1);

        // restart mid-COLLECT discards earlier failures
        tick(1'b1, 1'b0, '0);
        tick(1'b0, 1'b1, 16'h0000);
        tick(1'b0, 1'b1, 16'h00F0);
        run4(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        check_eq("restart_map", 32'(o_lane_map), 32'd3);

        // start with a simultaneous sample: sample dropped
        tick(1'b1, 1'b0, '0);
        tick(1'b1, 1'b1, 16'h0000);
        for (int i = 0; i < IT; i++) tick(1'b0, 1'b1, 16'hFFFF);
        tick(1'b0, 1'b0, '0);
        check_eq("simul_map",  32'(o_lane_map), 32'd3);
        check_eq("simul_done", 32'(o_done),     32'd1);

        // reset during COLLECT after a failing run
        run4(16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        tick(1'b1, 1'b0, '0);
        tick(1'b0, 1'b1, 16'h1234);
        i_start        = 1'b0;
        i_result_valid = 1'b0;
        rst_n          = 1'b0;
        #1;
        model_reset();
        check_eq("midrst_map",  32'(o_lane_map), 32'd3);
        check_eq("midrst_busy", 32'(o_busy),     32'd0);
        check_eq("midrst_done", 32'(o_done),     32'd0);
        check_outputs();
        @(negedge CLK);
        rst_n = 1'b1;

        // start with no samples: watchdog ends the run, or COLLECT waits
        tick(1'b1, 1'b0, '0);
        for (int i = 0; i < TO + 4; i++) tick(1'b0, 1'b0, '0);
`ifdef FLS_TIMEOUT_EN
        check_eq("wd_timeout", 32'(o_timeout),  32'd1);
        check_eq("wd_fail",    32'(o_fail),     32'd1);
        check_eq("wd_map",     32'(o_lane_map), 32'd0);
`else
        check_eq("wait_busy", 32'(o_busy), 32'd1);
        check_eq("wait_done", 32'(o_done), 32'd0);
`endif

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            s = ($urandom_range(0, 24) == 0);
            v = ($urandom_range(0, 9) < 6);
            r = $urandom_range(0, 9);
            if (r < 6)      d = 16'hFFFF;
            else if (r < 9) d = 16'hFFFF & ~(16'h0001 << $urandom_range(0, NL - 1));
            else            d = NL'($urandom);
            tick(s, v, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
